// File: rtl/br_pkg.sv
// Shared definitions for the branch resolve unit: RV32I branch funct3 codes,
// PC increment and default widths.
package br_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int CNT_W_DEF = 16;
   localparam int PC_INC    = 4;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } br_op_e;

endpackage

// File: rtl/br_cmp.sv
// Combinational operand comparator: equality, signed less-than and unsigned
// less-than of rs1 against rs2.
module br_cmp
   import br_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            eq,
   output logic            lt,
   output logic            ltu
);

   assign eq  = (rs1 == rs2);
   assign lt  = ($signed(rs1) < $signed(rs2));
   assign ltu = (rs1 < rs2);

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: decodes the branch, computes direction and next PC,
// registers the result behind a valid/ready stage and keeps branch statistics.
module br_resolve_unit
   import br_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   input  logic             pred_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             taken,
   output logic [XLEN-1:0]  target,
   output logic             mispredict,
   output logic             illegal,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mp_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic            eq, lt, ltu;
   logic            d_taken, d_illegal, d_mispredict;
   logic [XLEN-1:0] d_target;
   logic            run_q;
   logic            accept, handshake;

   br_cmp #(.XLEN(XLEN)) u_cmp (
      .rs1 (rs1),
      .rs2 (rs2),
      .eq  (eq),
      .lt  (lt),
      .ltu (ltu)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      d_taken   = 1'b0;
      d_illegal = 1'b0;
      case (br_op_e'(funct3))
         BEQ:     d_taken = eq;
         BNE:     d_taken = !eq;
         BLT:     d_taken = lt;
         BGE:     d_taken = !lt;
         BLTU:    d_taken = ltu;
         BGEU:    d_taken = !ltu;
         default: d_illegal = 1'b1;
      endcase
   end

   assign d_target     = d_taken ? (pc + imm) : (pc + XLEN'(PC_INC));
   assign d_mispredict = !d_illegal && (d_taken ^ pred_taken);

   assign in_ready  = !out_valid || out_ready;
   assign handshake = out_valid && out_ready;
   assign accept    = in_valid && in_ready && run_q;

   // NOTE: run_q is 0 on the edge where rst_n releases, so that edge never accepts a request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         taken      <= 1'b0;
         target     <= '0;
         mispredict <= 1'b0;
         illegal    <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         taken      <= d_taken;
         target     <= d_target;
         mispredict <= d_mispredict;
         illegal    <= d_illegal;
      end else if (handshake) begin
         out_valid  <= 1'b0;
      end
   end

   // Counters only see legal results leaving the stage; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count <= '0;
         mp_count <= '0;
      end else if (clr_stats) begin
         br_count <= '0;
         mp_count <= '0;
      end else if (handshake && !illegal) begin
         if (br_count != CNT_MAX)              br_count <= br_count + CNT_ONE;
         if (mispredict && mp_count != CNT_MAX) mp_count <= mp_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_br_resolve_unit.sv
// Self-checking bench for br_resolve_unit: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_br_resolve_unit;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic             clk, rst_n;
   logic             in_valid, in_ready;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  rs1, rs2, pc, imm;
   logic             pred_taken;
   logic             out_valid, out_ready;
   logic             taken, mispredict, illegal;
   logic [XLEN-1:0]  target;
   logic             clr_stats;
   logic [CNT_W-1:0] br_count, mp_count;

   int checks = 0;
   int errors = 0;

   br_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .funct3     (funct3),
      .rs1        (rs1),
      .rs2        (rs2),
      .pc         (pc),
      .imm        (imm),
      .pred_taken (pred_taken),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .taken      (taken),
      .target     (target),
      .mispredict (mispredict),
      .illegal    (illegal),
      .clr_stats  (clr_stats),
      .br_count   (br_count),
      .mp_count   (mp_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] target;
      logic            mp;
      logic            ill;
   } res_t;

   function automatic res_t resolve(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                                    input logic [XLEN-1:0] i, input logic pt);
      res_t r;
      r.taken = 1'b0;
      r.ill   = 1'b0;
      case (f3)
         3'd0: r.taken = (a == b);
         3'd1: r.taken = (a != b);
         3'd4: r.taken = ($signed(a) <  $signed(b));
         3'd5: r.taken = ($signed(a) >= $signed(b));
         3'd6: r.taken = (a <  b);
         3'd7: r.taken = (a >= b);
         default: r.ill = 1'b1;
      endcase
      r.target = r.taken ? p + i : p + 32'd4;
      r.mp     = r.ill ? 1'b0 : (r.taken != pt);
      return r;
   endfunction

   logic m_valid, m_run, m_hs, m_acc;
   res_t m_res;
   int   m_br, m_mp;

   assign m_hs  = m_valid && out_ready;
   assign m_acc = m_run && in_valid && (!m_valid || out_ready);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_run   <= 1'b0;
         m_res   <= '0;
         m_br    <= 0;
         m_mp    <= 0;
      end else begin
         m_run <= 1'b1;
         if (clr_stats) begin
            m_br <= 0;
            m_mp <= 0;
         end else if (m_hs && !m_res.ill) begin
            m_br <= (m_br < CMAX) ? m_br + 1 : CMAX;
            if (m_res.mp) m_mp <= (m_mp < CMAX) ? m_mp + 1 : CMAX;
         end
         if (m_acc) begin
            m_valid <= 1'b1;
            m_res   <= resolve(funct3, rs1, rs2, pc, imm, pred_taken);
         end else if (m_hs) begin
            m_valid <= 1'b0;
         end
      end
   end

   // Compare process: outputs are checked every cycle at the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 1);
         check("rst_br_count", br_count, 0);
         check("rst_target", target, 0);
      end else begin
         check("m_out_valid", out_valid, m_valid);
         check("m_in_ready", in_ready, !m_valid || out_ready);
         check("m_br_count", br_count, m_br);
         check("m_mp_count", mp_count, m_mp);
         if (m_valid) begin
            check("m_taken", taken, m_res.taken);
            check("m_target", target, m_res.target);
            check("m_mispredict", mispredict, m_res.mp);
            check("m_illegal", illegal, m_res.ill);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                        input logic [XLEN-1:0] i, input logic pt, input logic ordy);
      in_valid   = v;
      funct3     = f3;
      rs1        = a;
      rs2        = b;
      pc         = p;
      imm        = i;
      pred_taken = pt;
      out_ready  = ordy;
   endtask

   task automatic clear_stats();
      drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b1);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      clr_stats = 1'b0;
      drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b0);
      #3;
      check("init_in_ready", in_ready, 1);
      check("init_out_valid", out_valid, 0);
      check("init_mp_count", mp_count, 0);
      #9 rst_n = 1'b1;
      tick();
      tick();

      // Signed vs unsigned compare, target wrap, illegal funct3.
      clear_stats();
      drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h10, 1'b1, 1'b1);
      tick();
      check("blt_valid", out_valid, 1);
      check("blt_taken", taken, 1);
      check("blt_target", target, 32'h110);
      drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h10, 1'b0, 1'b1);
      tick();
      check("bltu_taken", taken, 0);
      check("bltu_target", target, 32'h104);
      check("bltu_br_count", br_count, 1);
      drive(1'b1, 3'b000, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b1);
      tick();
      check("beq_wrap_target", target, 32'h10);
      check("beq_mispredict", mispredict, 1);
      check("beq_mp_before", mp_count, 0);
      drive(1'b1, 3'b010, 32'd7, 32'd7, 32'h40, 32'h8, 1'b1, 1'b1);
      tick();
      check("beq_mp_count", mp_count, 1);
      check("ill_illegal", illegal, 1);
      check("ill_taken", taken, 0);
      check("ill_mispredict", mispredict, 0);
      drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b1);
      tick();
      check("ill_drain_valid", out_valid, 0);
      check("ill_br_count", br_count, 3);
      check("ill_mp_count", mp_count, 1);

      // Back-pressure: hold for 3 cycles, then one result per cycle.
      clear_stats();
      drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h1000, 32'h40, 1'b1, 1'b0);
      tick();
      check("stall_a_valid", out_valid, 1);
      check("stall_a_target", target, 32'h1040);
      drive(1'b1, 3'b000, 32'd3, 32'd3, 32'h2000, 32'h80, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_in_ready", in_ready, 0);
         check("stall_hold_target", target, 32'h1040);
         check("stall_hold_taken", taken, 1);
      end
      out_ready = 1'b1;
      tick();
      check("stall_b_target", target, 32'h2080);
      check("stall_b_valid", out_valid, 1);
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 3'b001, k, 0, 32'h100 * k, 32'd8, 1'b1, 1'b1);
         tick();
         check("b2b_target", target, 32'h100 * k + 8);
         check("b2b_valid", out_valid, 1);
      end
      drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b1);
      tick();
      check("b2b_drain_valid", out_valid, 0);
      check("b2b_br_count", br_count, 6);
      check("b2b_mp_count", mp_count, 0);

      // Counter saturation, then clear colliding with a handshake.
      clear_stats();
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 3'b000, 32'd1, 32'd1, 32'h400, 32'h4, 1'b0, 1'b1);
         tick();
      end
      drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b1);
      tick();
      check("sat_br_count", br_count, 15);
      check("sat_mp_count", mp_count, 15);
      drive(1'b1, 3'b000, 32'd1, 32'd1, 32'h400, 32'h4, 1'b0, 1'b1);
      tick();
      drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b1);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("clr_hs_br_count", br_count, 0);
      check("clr_hs_mp_count", mp_count, 0);

      // Randomized traffic checked by the model.
      for (int n = 0; n < 3000; n++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         funct3     = 3'($urandom_range(0, 7));
         rs1        = $urandom;
         case ($urandom_range(0, 3))
            0:       rs2 = rs1;
            1:       rs2 = rs1 ^ 32'h8000_0000;
            2:       rs2 = 32'($urandom_range(0, 3));
            default: rs2 = $urandom;
         endcase
         pc         = $urandom;
         imm        = $urandom;
         pred_taken = 1'($urandom_range(0, 1));
         clr_stats  = ($urandom_range(0, 39) == 0);
         tick();
      end
      clr_stats = 1'b0;

      // Asynchronous reset while a result is pending.
      drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 3'b001, 32'd1, 32'd0, 32'h800, 32'h10, 1'b0, 1'b0);
      tick();
      check("pre_rst_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_in_ready", in_ready, 1);
      check("async_rst_br_count", br_count, 0);
      check("async_rst_mp_count", mp_count, 0);
      check("async_rst_taken", taken, 0);
      out_ready = 1'b1;
      @(negedge clk);
      #3 rst_n = 1'b1;
      tick();
      check("no_accept_on_release", out_valid, 0);
      tick();
      check("accept_after_release", out_valid, 1);
      check("accept_after_release_target", target, 32'h810);
      drive(1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 1'b1);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/br_resolve_unit.md
BR_RESOLVE_UNIT -- requirements
Module: br_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: operand, PC and immediate width in bits; legal range 8..64.
REQ-002 Parameter CNT_W, default 16: width of each statistics counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed first as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when high with in_valid.
- funct3  in  3  branch type, RV32I encoding.
- rs1  in  XLEN  first operand.
- rs2  in  XLEN  second operand.
- pc  in  XLEN  branch PC.
- imm  in  XLEN  sign-extended B-immediate.
- pred_taken  in  1  front-end prediction.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- taken  out  1  resolved direction.
- target  out  XLEN  next PC.
- mispredict  out  1  taken differs from pred_taken.
- illegal  out  1  funct3 is not a branch.
- clr_stats  in  1  synchronous clear of the counters.
- br_count  out  CNT_W  resolved branches.
- mp_count  out  CNT_W  mispredicts.

Function
REQ-004 Decode SHALL be: 000 BEQ (rs1==rs2); 001 BNE; 100 BLT (signed <); 101 BGE (signed >=); 110 BLTU (unsigned <); 111 BGEU (unsigned >=).
REQ-005 For funct3 010 or 011, the block SHALL set illegal=1, taken=0 and mispredict=0.
REQ-006 target SHALL be pc+imm when taken=1 and pc+4 otherwise, computed modulo 2^XLEN with wrap-around and no overflow flag.
REQ-007 Outside the illegal case, mispredict SHALL equal taken XOR pred_taken.
REQ-008 There SHALL be a single output register stage with latency 1: a request accepted at edge N drives out_valid and the result at edge N.
REQ-009 in_ready SHALL equal (!out_valid || out_ready), a combinational path with no bubble, giving full throughput of one per cycle.
REQ-010 While out_valid=1 && out_ready=0, all outputs SHALL hold stable.
REQ-011 out_valid SHALL clear on a consumer handshake when no new request is accepted in the same cycle.
REQ-012 A simultaneous consumer handshake and new accept SHALL replace the result and keep out_valid=1.
REQ-013 On each output handshake (out_valid && out_ready) with illegal=0, br_count SHALL increment by 1, and mp_count SHALL also increment by 1 if mispredict=1.
REQ-014 Both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-015 clr_stats SHALL zero both counters at the next edge and take priority over a same-cycle increment.

Reset
REQ-016 While rst_n=0, the block SHALL immediately force out_valid=0, taken=0, target=0, mispredict=0, illegal=0, br_count=0 and mp_count=0.
REQ-017 in_ready SHALL read 1 during reset.
REQ-018 Reset asserted mid-transfer SHALL discard the pending result.
REQ-019 No request SHALL be accepted on the edge at which rst_n deasserts.

Structure
REQ-020 A shared package br_pkg SHALL hold the funct3 enum (BEQ, BNE, BLT, BGE, BLTU, BGEU), the PC increment constant 4, and the default XLEN/CNT_W values.
REQ-021 Comparison SHALL live in a combinational sub-module br_cmp #(XLEN) with outputs eq, lt and ltu; br_resolve_unit SHALL hold the decode, target adder, pipeline register and counters.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- XLEN=32, BLT with rs1=0xFFFFFFFF, rs2=1 -> taken=1; BLTU with the same operands -> taken=0; each result one cycle after accept.
- BEQ, rs1=rs2=5, pc=0xFFFFFFF0, imm=0x20, pred_taken=0 -> target=0x00000010, mispredict=1, mp_count +1.
- funct3=010, pred_taken=1 -> illegal=1, taken=0, mispredict=0, br_count unchanged.
- out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; then out_ready=1 with back-to-back requests -> one result per cycle, none lost or duplicated.
- CNT_W=4, 20 mispredicting branches -> br_count=mp_count=15; clr_stats pulsed in the same cycle as a handshake -> both counters 0.
- rst_n dropped asynchronously while out_valid=1 -> out_valid=0 before the next edge, counters 0, in_ready=1.
